// File: rtl/ad9516_cfg_sequencer.sv
// AD9516 power-up configurator: pulses the chip reset, streams a register table out through an SPI write engine, then issues an IO update.
// Optional handshake watchdog is compiled in when AD9516_CFG_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ad9516_cfg_sequencer #(
    parameter int NUM_REGS       = 64,
    parameter int RST_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        o_adk_rst_n,
    output logic [6:0]  tbl_addr,
    input  logic [23:0] tbl_entry,
    output logic        spi_valid,
    output logic [23:0] spi_word,
    input  logic        spi_ready,
    input  logic        spi_done
);

    // One counter serves both reset phases and the watchdog, so it is sized for the larger limit.
    localparam int              CNT_MAX        = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int              CNT_W          = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST      = CNT_W'(RST_CYCLES - 1);
    localparam logic [6:0]      IDX_LAST       = 7'(NUM_REGS - 1);
    localparam logic [23:0]     IO_UPDATE_WORD = 24'h023201;

    typedef enum logic [3:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        FETCH,
        LOAD,
        SEND,
        WAIT_DONE,
        UPDATE,
        FINISH,
        ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_index;
    logic             r_upd;
    logic [23:0]      r_spi_word;
    logic             w_rst_last;
    logic             w_wdog_hit;
    logic             w_accept;

    assign w_rst_last = (r_cnt == RST_LAST);
    assign w_accept   = (r_state == IDLE || r_state == FINISH || r_state == ERROR) && start;

`ifdef AD9516_CFG_TIMEOUT_EN
    assign w_wdog_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, FINISH, ERROR: begin
                if (start) w_next = RST_LOW;
            end
            RST_LOW: begin
                if (w_rst_last) w_next = RST_WAIT;
            end
            RST_WAIT: begin
                if (w_rst_last) w_next = FETCH;
            end
            FETCH:  w_next = LOAD;
            LOAD:   w_next = SEND;
            SEND: begin
                if (spi_ready)       w_next = WAIT_DONE;
                else if (w_wdog_hit) w_next = ERROR;
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    if (r_upd)                    w_next = FINISH;
                    else if (r_index == IDX_LAST) w_next = UPDATE;
                    else                          w_next = FETCH;
                end else if (w_wdog_hit) begin
                    w_next = ERROR;
                end
            end
            UPDATE:  w_next = SEND;
            default: w_next = IDLE;
        endcase
    end

    // The counter restarts on every state change, giving per-phase cycle counts.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt      <= '0;
            r_index    <= '0;
            r_upd      <= 1'b0;
            r_spi_word <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            if (w_accept) begin
                r_index <= '0;
                r_upd   <= 1'b0;
            end
            if (r_state == WAIT_DONE && spi_done && !r_upd && r_index != IDX_LAST) begin
                r_index <= r_index + 7'd1;
            end
            if (r_state == LOAD) begin
                r_spi_word <= tbl_entry;
            end
            if (r_state == UPDATE) begin
                r_spi_word <= IO_UPDATE_WORD;
                r_upd      <= 1'b1;
            end
        end
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        o_adk_rst_n = 1'b1;
        spi_valid   = 1'b0;
        case (r_state)
            RST_LOW: begin
                busy        = 1'b1;
                o_adk_rst_n = 1'b0;
            end
            RST_WAIT, FETCH, LOAD, WAIT_DONE, UPDATE: begin
                busy = 1'b1;
            end
            SEND: begin
                busy      = 1'b1;
                spi_valid = 1'b1;
            end
            FINISH: begin
                done = 1'b1;
            end
`ifdef AD9516_CFG_TIMEOUT_EN
            ERROR: begin
                err = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign tbl_addr = r_index;
    assign spi_word = r_spi_word;

endmodule

// File: tb/tb_ad9516_cfg_sequencer.sv
// Bench for ad9516_cfg_sequencer: transaction-level reference model plus an SPI engine responder.
// Build with AD9516_CFG_TIMEOUT_EN defined to exercise the watchdog.
`timescale 1ns/1ps
module tb_ad9516_cfg_sequencer;

    localparam int NREG = 3;
    localparam int RSTC = 4;
    localparam int TO   = 16;
`ifdef AD9516_CFG_TIMEOUT_EN
    localparam bit WDOG     = 1'b1;
    localparam int DET_DONE = 10;
`else
    localparam bit WDOG     = 1'b0;
    localparam int DET_DONE = 30;
`endif

    logic        clk_in    = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic        spi_ready = 1'b0;
    logic        spi_done  = 1'b0;
    logic        busy, done, err, o_adk_rst_n, spi_valid;
    logic [6:0]  tbl_addr;
    logic [23:0] tbl_entry;
    logic [23:0] spi_word;
    logic [23:0] tbl [0:127];

    int checks   = 0;
    int failures = 0;

    ad9516_cfg_sequencer #(
        .NUM_REGS(NREG),
        .RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .err(err),
        .o_adk_rst_n(o_adk_rst_n),
        .tbl_addr(tbl_addr),
        .tbl_entry(tbl_entry),
        .spi_valid(spi_valid),
        .spi_word(spi_word),
        .spi_ready(spi_ready),
        .spi_done(spi_done)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous table ROM: data follows the address by one cycle.
    always @(posedge clk_in) tbl_entry <= tbl[tbl_addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the run as a queue of pending frames and the edge numbers at which
    // each visible event must happen.
    int          edgeCnt = 0;
    bit          mBusy = 0, mDone = 0, mErr = 0;
    bit          wReady = 0, wDone = 0;
    int          validFrom = 0, hEdge = 0, startEdge = 0;
    logic [23:0] expQ [$];

    always @(posedge clk_in) begin : model
        edgeCnt++;
        if (rst) begin
            mBusy = 0; mDone = 0; mErr = 0; wReady = 0; wDone = 0;
            expQ.delete();
        end else if (!mBusy) begin
            if (start) begin
                mBusy = 1; mDone = 0; mErr = 0;
                startEdge = edgeCnt;
                expQ.delete();
                for (int i = 0; i < NREG; i++) expQ.push_back(tbl[i]);
                expQ.push_back(24'h023201);
                wReady = 1; wDone = 0;
                validFrom = edgeCnt + 2 * RSTC + 2;
            end
        end else if (wReady && edgeCnt > validFrom) begin
            if (spi_ready) begin
                void'(expQ.pop_front());
                wReady = 0; wDone = 1; hEdge = edgeCnt;
            end else if (WDOG && edgeCnt == validFrom + TO) begin
                mBusy = 0; mErr = 1; wReady = 0;
            end
        end else if (wDone && edgeCnt > hEdge) begin
            if (spi_done) begin
                wDone = 0;
                if (expQ.size() == 0) begin
                    mBusy = 0; mDone = 1;
                end else begin
                    wReady = 1;
                    validFrom = edgeCnt + ((expQ.size() == 1) ? 1 : 2);
                end
            end else if (WDOG && edgeCnt == hEdge + TO) begin
                mBusy = 0; mErr = 1; wDone = 0;
            end
        end
    end

    logic [23:0] frameLog [$];
    int          validCycles = 0, lowCycles = 0, acceptEdge = 0, errEdge = 0;
    bit          errSeen = 0;
    logic        expValid, expRstN;

    always @(negedge clk_in) begin : compare
        if (edgeCnt > 0) begin
            expValid = mBusy && wReady && (edgeCnt >= validFrom);
            expRstN  = !(mBusy && edgeCnt >= startEdge && edgeCnt < startEdge + RSTC);
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("adk_rst_n", 32'(o_adk_rst_n), 32'(expRstN));
            checkOutput("spi_valid", 32'(spi_valid), 32'(expValid));
            if (expValid && expQ.size() > 0) checkOutput("spi_word", 32'(spi_word), 32'(expQ[0]));
        end
        if (spi_valid && spi_ready && !rst) begin
            frameLog.push_back(spi_word);
            acceptEdge = edgeCnt + 1;
        end
        if (spi_valid) validCycles++;
        if (!o_adk_rst_n) lowCycles++;
        if (err && !errSeen) begin
            errSeen = 1;
            errEdge = edgeCnt;
        end
    end

    // SPI engine responder, driven 2 time units after each rising edge.
    int readyDelay = 0, readyCnt = 0, doneDelay = 1, doneCnt = 0;
    bit readyAlways = 0, spurious = 0, neverDone = 0, randDelays = 0;
    bit lastValid = 0, lastReady = 0;

    initial begin : responder
        forever begin
            @(posedge clk_in);
            #2;
            if (rst) begin
                doneCnt = 0; readyCnt = 0; spi_ready = 0; spi_done = 0;
                lastValid = 0; lastReady = 0;
            end else begin
                if (lastValid && lastReady) begin
                    if (!neverDone) doneCnt = randDelays ? int'($urandom_range(1, 12)) : doneDelay;
                    if (randDelays) readyDelay = int'($urandom_range(0, 5));
                end
                spi_done = 0;
                if (doneCnt > 0) begin
                    doneCnt--;
                    if (doneCnt == 0) spi_done = 1;
                end else if (spurious && spi_valid && $urandom_range(0, 2) == 0) begin
                    spi_done = 1;
                end
                if (readyAlways) begin
                    spi_ready = 1;
                end else if (spi_valid) begin
                    if (readyCnt >= readyDelay) spi_ready = 1;
                    else begin
                        spi_ready = 0;
                        readyCnt++;
                    end
                end else begin
                    spi_ready = spurious && ($urandom_range(0, 3) == 0);
                    readyCnt = 0;
                end
                lastValid = spi_valid;
                lastReady = spi_ready;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic startVal);
        tick(1);
        rst = rstVal; start = startVal;
        tick(1);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n = 0;
        @(negedge clk_in);
        while (busy && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("[TB] FAIL %s: busy=1 after %0d cycles, required 0", name, bound);
        end
    endtask

    task automatic checkFrames(input string name, input logic [23:0] exp [4]);
        checkOutput({name, "_count"}, 32'(frameLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < frameLog.size()) checkOutput({name, "_frame"}, 32'(frameLog[i]), 32'(exp[i]));
        end
    endtask

    task automatic runAndCheck(input string name, input logic [23:0] exp [4]);
        frameLog.delete(); validCycles = 0; lowCycles = 0;
        applyStimulus(1'b0, 1'b1);
        waitIdle(3000, name);
        checkFrames(name, exp);
        checkOutput({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic loadTableA();
        tbl[0] = 24'h000000; tbl[1] = 24'h001018; tbl[2] = 24'h01E000;
    endtask

    logic [23:0] expA [4] = '{24'h000000, 24'h001018, 24'h01E000, 24'h023201};
    logic [23:0] expR [4];
    logic [31:0] rnd;
    int          n;

    initial begin : main
        for (int i = 0; i < 128; i++) tbl[i] = 24'h0;
        rst = 1'b1;
        tick(3);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_adk_rst_n", 32'(o_adk_rst_n), 32'd1);
        checkOutput("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        checkOutput("rst_spi_valid", 32'(spi_valid), 32'd0);
        checkOutput("rst_spi_word", 32'(spi_word), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("[TB] basic run, ready after 2 cycles");
        loadTableA();
        readyDelay = 2; doneDelay = DET_DONE;
        runAndCheck("basic", expA);
        checkOutput("basic_rst_low_cycles", 32'(lowCycles), 32'd4);
        checkOutput("basic_busy_end", 32'(busy), 32'd0);

        $display("[TB] ready held high");
        readyAlways = 1;
        runAndCheck("ready_high", expA);
        checkOutput("ready_high_valid_cycles", 32'(validCycles), 32'd4);
        readyAlways = 0;

        $display("[TB] start while busy, spurious done and ready");
        spurious = 1; readyDelay = 1;
        frameLog.delete();
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(9);
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
        waitIdle(3000, "restart_ignore");
        checkFrames("restart_ignore", expA);
        spurious = 0;

        $display("[TB] reset during second frame wait");
        frameLog.delete();
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (frameLog.size() < 2 && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("mid_reset_reached_frame2", 32'(frameLog.size()), 32'd2);
        tick(2);
        rst = 1'b1;
        tick(1);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_valid", 32'(spi_valid), 32'd0);
        checkOutput("mid_reset_word", 32'(spi_word), 32'd0);
        checkOutput("mid_reset_addr", 32'(tbl_addr), 32'd0);
        checkOutput("mid_reset_rst_n", 32'(o_adk_rst_n), 32'd1);
        rst = 1'b0;
        runAndCheck("after_reset", expA);

        $display("[TB] randomized runs");
        randDelays = 1; spurious = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREG; i++) begin
                rnd = $urandom;
                tbl[i] = rnd[23:0];
                expR[i] = rnd[23:0];
            end
            expR[3] = 24'h023201;
            runAndCheck("random", expR);
        end
        randDelays = 0; spurious = 0;

        $display("[TB] engine never signals done");
        loadTableA();
        readyDelay = 1; neverDone = 1; errSeen = 0;
        frameLog.delete();
        applyStimulus(1'b0, 1'b1);
`ifdef AD9516_CFG_TIMEOUT_EN
        waitIdle(500, "watchdog");
        checkOutput("watchdog_err", 32'(err), 32'd1);
        checkOutput("watchdog_busy", 32'(busy), 32'd0);
        checkOutput("watchdog_latency", 32'(errEdge - acceptEdge), 32'(TO));
        neverDone = 0;
        runAndCheck("watchdog_rerun", expA);
        checkOutput("watchdog_rerun_err", 32'(err), 32'd0);
`else
        tick(1000);
        checkOutput("nowdog_busy", 32'(busy), 32'd1);
        checkOutput("nowdog_err", 32'(err), 32'd0);
        checkOutput("nowdog_err_seen", 32'(errSeen), 32'd0);
        neverDone = 0;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk_in);
        checkOutput("nowdog_reset_busy", 32'(busy), 32'd0);
`endif

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global time limit reached");
    end

endmodule

// File: doc/ad9516_cfg_sequencer.md
AD9516_CFG_SEQUENCER -- requirements
Module: ad9516_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 64, number of table entries written per run (1..128).
REQ-002 SHALL have parameter RST_CYCLES, default 100, cycle count for each of the device-reset low phase and the post-reset wait.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit per handshake wait.
REQ-004 SHALL have ports, clock and reset first:
- clk_in  input  1  system clock; one clock domain, all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle request to run the full configuration sequence.
- busy  output  1  sequence in progress.
- done  output  1  sequence completed; sticky.
- err  output  1  watchdog fault; sticky.
- o_adk_rst_n  output  1  AD9516 hard reset, active low.
- tbl_addr  output  7  configuration table read index.
- tbl_entry  input  24  table word, {addr[15:0], data[7:0]}; valid 1 cycle after tbl_addr changes.
- spi_valid  output  1  frame request to the SPI write engine.
- spi_word  output  24  frame to send, {instruction/addr[15:0], data[7:0]}.
- spi_ready  input  1  engine accepts the frame.
- spi_done  input  1  single-cycle pulse: engine finished shifting the frame, CS deasserted.

Function
REQ-005 SHALL implement states IDLE, RST_LOW, RST_WAIT, FETCH, LOAD, SEND, WAIT_DONE, UPDATE, FINISH, ERROR.
REQ-006 SHALL, in IDLE, FINISH or ERROR with start=1, clear done and err, set busy=1, set index=0 and enter RST_LOW on the next cycle.
REQ-007 SHALL ignore start while busy=1.
REQ-008 SHALL drive o_adk_rst_n=0 for exactly RST_CYCLES cycles in RST_LOW, then drive it high and hold RST_WAIT for RST_CYCLES cycles before entering FETCH.
REQ-009 SHALL present tbl_addr=index in FETCH and register tbl_entry into spi_word in LOAD, one cycle later.
REQ-010 SHALL, in SEND, assert spi_valid with spi_word stable until the first cycle with spi_valid=1 and spi_ready=1, then deassert spi_valid on the next cycle and enter WAIT_DONE.
REQ-011 SHALL, in WAIT_DONE on spi_done=1: if index<NUM_REGS-1, increment index and enter FETCH; otherwise enter UPDATE.
REQ-012 SHALL, in UPDATE, load spi_word=24'h023201 (IO update register 0x232 = 0x01) and send it with the same SEND/WAIT_DONE handshake, then enter FINISH.
REQ-013 SHALL, in FINISH, set done=1 and busy=0; done holds until the next accepted start or rst.
REQ-014 SHALL ignore spi_done outside WAIT_DONE and spi_ready outside SEND.
REQ-015 SHALL treat spi_ready=1 on the very first SEND cycle as immediate acceptance; spi_valid is high for exactly one cycle.
REQ-016 SHALL send exactly NUM_REGS+1 frames per successful run, in table order from index 0.

Reset
REQ-017 SHALL, on rst=1 at a clock edge, enter IDLE and drive busy=0, done=0, err=0, o_adk_rst_n=1, tbl_addr=0, spi_valid=0, spi_word=0, with index and counters cleared.
REQ-018 SHALL, on rst mid-run, drop spi_valid on the next edge and abandon the sequence without completing the current frame handshake.

Configuration
REQ-019 SHALL compile the watchdog only when macro AD9516_CFG_TIMEOUT_EN is defined.
REQ-020 SHALL, with AD9516_CFG_TIMEOUT_EN, count cycles spent in SEND or WAIT_DONE (counter cleared on each state entry); on reaching TIMEOUT_CYCLES: spi_valid=0, busy=0, err=1, enter ERROR.
REQ-021 SHALL, without AD9516_CFG_TIMEOUT_EN, wait indefinitely in SEND/WAIT_DONE; err is tied to 0.

Verification
REQ-022 NUM_REGS=3, RST_CYCLES=4, table {000000h,001018h,01E000h}, engine ready after 2 cycles, done 30 cycles later -> frames 000000h,001018h,01E000h,023201h in order; done=1; o_adk_rst_n low for exactly 4 cycles.
REQ-023 spi_ready held high throughout -> spi_valid high exactly one cycle per frame; 4 frames total.
REQ-024 start pulsed again while busy, and spurious spi_done during SEND -> no restart, no skipped frame, output sequence identical to REQ-022.
REQ-025 rst asserted during second frame's WAIT_DONE, then start -> all outputs at reset values next cycle; rerun sends full 4-frame sequence from index 0.
REQ-026 With AD9516_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=16, spi_done never pulses -> err=1 and busy=0 exactly 16 cycles after WAIT_DONE entry; next start clears err and reruns.
REQ-027 Without AD9516_CFG_TIMEOUT_EN, same stimulus -> busy stays 1 and err stays 0 for 1000 cycles.
